// File: rtl/hs_burst_source.sv
// hs_burst_source
//   Producer stage for valid/ready handshake experiments. Emits bursts of
//   BURST_LEN incrementing words, holds each word until it is accepted, and
//   inserts GAP_CYC idle cycles between bursts. The data sequence continues
//   across bursts (it is not restarted per burst) and wraps modulo 2^DATA_W.
//
// Ports
//   sys_clk    : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   enable     : permission to start a new burst (sampled in IDLE and at
//                burst boundaries only)
//   ready_in   : downstream ready
//   valid_out  : data_out valid
//   data_out   : payload word
//   last_out   : high with the final beat of each burst
//   burst_cnt  : completed bursts, wraps 255 -> 0
//   busy       : high whenever the FSM is not in IDLE
//
// Every output is a flop; ready_in only influences next-state decisions, so
// there is no combinational path from ready_in to any output.
module hs_burst_source #(
    parameter int          DATA_W    = 8,
    parameter int          BURST_LEN = 4,
    parameter int          GAP_CYC   = 2,
    parameter int unsigned START_VAL = 0
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              ready_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              last_out,
    output logic [7:0]        burst_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [7:0]        LAST_IDX      = 8'(BURST_LEN - 1);
    // Only meaningful when GAP_CYC > 0; GAP is never entered otherwise.
    localparam logic [7:0]        GAP_LAST      = 8'(GAP_CYC - 1);
    localparam logic              HAS_GAP       = (GAP_CYC > 0);
    // A burst's first beat is also its last one when BURST_LEN == 1.
    localparam logic              FIRST_IS_LAST = (BURST_LEN == 1);
    localparam logic [DATA_W-1:0] DATA_START    = DATA_W'(START_VAL);
    localparam logic [DATA_W-1:0] DATA_ONE      = DATA_W'(1);

    state_t     state_reg;
    logic [7:0] beat_idx_reg;
    logic [7:0] gap_cnt_reg;

    logic xfer;
    assign xfer = valid_out & ready_in;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            valid_out    <= 1'b0;
            last_out     <= 1'b0;
            busy         <= 1'b0;
            data_out     <= DATA_START;
            burst_cnt    <= 8'd0;
            beat_idx_reg <= 8'd0;
            gap_cnt_reg  <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (enable) begin
                        state_reg <= SEND;
                        valid_out <= 1'b1;
                        last_out  <= FIRST_IS_LAST;
                        busy      <= 1'b1;
                    end
                end

                SEND: begin
                    // Without xfer nothing changes: word, last flag and valid hold.
                    if (xfer) begin
                        data_out <= data_out + DATA_ONE;
                        if (beat_idx_reg == LAST_IDX) begin
                            beat_idx_reg <= 8'd0;
                            burst_cnt    <= burst_cnt + 8'd1;
                            if (HAS_GAP) begin
                                state_reg   <= GAP;
                                valid_out   <= 1'b0;
                                last_out    <= 1'b0;
                                gap_cnt_reg <= 8'd0;
                            end else if (enable) begin
                                // Back-to-back: next burst's first word next cycle.
                                state_reg <= SEND;
                                valid_out <= 1'b1;
                                last_out  <= FIRST_IS_LAST;
                            end else begin
                                state_reg <= IDLE;
                                valid_out <= 1'b0;
                                last_out  <= 1'b0;
                                busy      <= 1'b0;
                            end
                        end else begin
                            beat_idx_reg <= beat_idx_reg + 8'd1;
                            last_out     <= ((beat_idx_reg + 8'd1) == LAST_IDX);
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg <= 8'd0;
                        if (enable) begin
                            state_reg <= SEND;
                            valid_out <= 1'b1;
                            last_out  <= FIRST_IS_LAST;
                        end else begin
                            state_reg <= IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 8'd1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    valid_out <= 1'b0;
                    last_out  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs_burst_source.sv
// Directed bench for hs_burst_source. Three instances cover the default
// configuration, a zero-gap wrapping configuration and single-beat bursts.
// Each table row drives one instance for one clock; unselected instances
// are held in reset.
module tb_hs_burst_source;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic       rst_s [3];
    logic       en_s  [3];
    logic       rdy_s [3];
    logic       v_o   [3];
    logic [7:0] d_o   [3];
    logic       l_o   [3];
    logic [7:0] c_o   [3];
    logic       b_o   [3];

    hs_burst_source #(.DATA_W(8), .BURST_LEN(4), .GAP_CYC(2), .START_VAL(0)) dut0 (
        .sys_clk(sys_clk), .rst(rst_s[0]), .enable(en_s[0]), .ready_in(rdy_s[0]),
        .valid_out(v_o[0]), .data_out(d_o[0]), .last_out(l_o[0]),
        .burst_cnt(c_o[0]), .busy(b_o[0]));

    hs_burst_source #(.DATA_W(8), .BURST_LEN(4), .GAP_CYC(0), .START_VAL(8'hFC)) dut1 (
        .sys_clk(sys_clk), .rst(rst_s[1]), .enable(en_s[1]), .ready_in(rdy_s[1]),
        .valid_out(v_o[1]), .data_out(d_o[1]), .last_out(l_o[1]),
        .burst_cnt(c_o[1]), .busy(b_o[1]));

    hs_burst_source #(.DATA_W(8), .BURST_LEN(1), .GAP_CYC(1), .START_VAL(0)) dut2 (
        .sys_clk(sys_clk), .rst(rst_s[2]), .enable(en_s[2]), .ready_in(rdy_s[2]),
        .valid_out(v_o[2]), .data_out(d_o[2]), .last_out(l_o[2]),
        .burst_cnt(c_o[2]), .busy(b_o[2]));

    typedef struct {
        int         sel;
        logic       rst;
        logic       en;
        logic       rdy;
        logic       v;
        logic [7:0] d;
        logic       l;
        logic [7:0] c;
        logic       b;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int idx, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Drive one instance for one clock, keep the others in reset.
    task automatic drive(input int sel, input logic r, input logic e, input logic y);
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = (k == sel) ? r : 1'b1;
            en_s[k]  = e;
            rdy_s[k] = y;
        end
        @(posedge sys_clk);
        #1;
    endtask

    task automatic add(input int s, input logic r, input logic e, input logic y,
                       input logic v, input logic [7:0] d, input logic l,
                       input logic [7:0] c, input logic b);
        vecs.push_back('{s, r, e, y, v, d, l, c, b});
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1; en_s[k] = 1'b0; rdy_s[k] = 1'b0;
        end

        // ---- dut0: defaults (BURST_LEN 4, GAP 2, START 0) ----
        //   sel rst en rdy  v  d   l  c  b
        add(0, 1, 0, 1,  0, 0,  0, 0, 0);   // reset / idle
        add(0, 1, 0, 1,  0, 0,  0, 0, 0);
        add(0, 0, 1, 1,  1, 0,  0, 0, 1);   // full rate burst
        add(0, 0, 1, 1,  1, 1,  0, 0, 1);
        add(0, 0, 1, 1,  1, 2,  0, 0, 1);
        add(0, 0, 1, 1,  1, 3,  1, 0, 1);
        add(0, 0, 1, 1,  0, 4,  0, 1, 1);   // gap cycle 1
        add(0, 0, 1, 1,  0, 4,  0, 1, 1);   // gap cycle 2
        add(0, 0, 1, 1,  1, 4,  0, 1, 1);
        add(0, 0, 1, 1,  1, 5,  0, 1, 1);
        add(0, 0, 1, 1,  1, 6,  0, 1, 1);
        add(0, 0, 1, 1,  1, 7,  1, 1, 1);
        add(0, 0, 1, 1,  0, 8,  0, 2, 1);
        add(0, 0, 1, 1,  0, 8,  0, 2, 1);
        add(0, 0, 1, 0,  1, 8,  0, 2, 1);   // backpressure 0,1,0,0,1,0,1,1
        add(0, 0, 1, 0,  1, 8,  0, 2, 1);
        add(0, 0, 1, 1,  1, 9,  0, 2, 1);
        add(0, 0, 1, 0,  1, 9,  0, 2, 1);
        add(0, 0, 1, 0,  1, 9,  0, 2, 1);
        add(0, 0, 1, 1,  1, 10, 0, 2, 1);
        add(0, 0, 1, 0,  1, 10, 0, 2, 1);
        add(0, 0, 1, 1,  1, 11, 1, 2, 1);
        add(0, 0, 1, 0,  1, 11, 1, 2, 1);   // last beat held under stall
        add(0, 0, 1, 1,  0, 12, 0, 3, 1);
        add(0, 0, 1, 1,  0, 12, 0, 3, 1);
        add(0, 0, 1, 1,  1, 12, 0, 3, 1);
        add(0, 0, 0, 1,  1, 13, 0, 3, 1);   // enable drops after first beat
        add(0, 0, 0, 1,  1, 14, 0, 3, 1);
        add(0, 0, 0, 1,  1, 15, 1, 3, 1);
        add(0, 0, 0, 1,  0, 16, 0, 4, 1);
        add(0, 0, 0, 1,  0, 16, 0, 4, 1);
        add(0, 0, 0, 1,  0, 16, 0, 4, 0);   // gap end, enable low -> IDLE
        add(0, 0, 0, 1,  0, 16, 0, 4, 0);
        add(0, 0, 1, 0,  1, 16, 0, 4, 1);
        add(0, 0, 0, 1,  1, 17, 0, 4, 1);
        add(0, 0, 0, 0,  1, 17, 0, 4, 1);
        add(0, 1, 1, 1,  0, 0,  0, 0, 0);   // reset mid-burst with ready high
        add(0, 0, 1, 1,  1, 0,  0, 0, 1);
        add(0, 0, 1, 1,  1, 1,  0, 0, 1);

        // ---- dut1: GAP 0, START FC: wrap and back-to-back ----
        add(1, 1, 0, 1,  0, 8'hFC, 0, 0, 0);
        add(1, 0, 1, 1,  1, 8'hFC, 0, 0, 1);
        add(1, 0, 1, 1,  1, 8'hFD, 0, 0, 1);
        add(1, 0, 1, 1,  1, 8'hFE, 0, 0, 1);
        add(1, 0, 1, 1,  1, 8'hFF, 1, 0, 1);
        add(1, 0, 1, 1,  1, 8'h00, 0, 1, 1);
        add(1, 0, 1, 1,  1, 8'h01, 0, 1, 1);
        add(1, 0, 1, 1,  1, 8'h02, 0, 1, 1);
        add(1, 0, 1, 1,  1, 8'h03, 1, 1, 1);
        add(1, 0, 0, 1,  0, 8'h04, 0, 2, 0);
        add(1, 0, 0, 1,  0, 8'h04, 0, 2, 0);

        // ---- dut2: BURST_LEN 1, GAP 1 ----
        add(2, 1, 0, 0,  0, 0, 0, 0, 0);
        add(2, 0, 1, 1,  1, 0, 1, 0, 1);
        add(2, 0, 1, 1,  0, 1, 0, 1, 1);
        add(2, 0, 1, 0,  1, 1, 1, 1, 1);
        add(2, 0, 1, 0,  1, 1, 1, 1, 1);
        add(2, 0, 1, 1,  0, 2, 0, 2, 1);
        add(2, 0, 0, 1,  0, 2, 0, 2, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].sel, vecs[i].rst, vecs[i].en, vecs[i].rdy);
            $display("step %0d dut%0d rst=%0b en=%0b rdy=%0b -> v=%0b d=%02h l=%0b c=%0d b=%0b",
                     i, vecs[i].sel, vecs[i].rst, vecs[i].en, vecs[i].rdy,
                     v_o[vecs[i].sel], d_o[vecs[i].sel], l_o[vecs[i].sel],
                     c_o[vecs[i].sel], b_o[vecs[i].sel]);
            check("valid", i, 8'(v_o[vecs[i].sel]), 8'(vecs[i].v));
            check("data",  i, d_o[vecs[i].sel], vecs[i].d);
            check("last",  i, 8'(l_o[vecs[i].sel]), 8'(vecs[i].l));
            check("count", i, c_o[vecs[i].sel], vecs[i].c);
            check("busy",  i, 8'(b_o[vecs[i].sel]), 8'(vecs[i].b));
        end

        // ---- long stall on dut0: word 2 must hold, then advance once ----
        drive(0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1, 1'b1);   // first word 0 presented
        drive(0, 1'b0, 1'b1, 1'b1);   // word 1
        drive(0, 1'b0, 1'b1, 1'b1);   // word 2
        for (int n = 0; n < 12; n++) begin
            drive(0, 1'b0, 1'b0, 1'b0);
            $display("stall %0d -> v=%0b d=%02h l=%0b", n, v_o[0], d_o[0], l_o[0]);
            check("stall_valid", n, 8'(v_o[0]), 8'd1);
            check("stall_data",  n, d_o[0], 8'd2);
            check("stall_last",  n, 8'(l_o[0]), 8'd0);
        end
        drive(0, 1'b0, 1'b0, 1'b1);
        $display("release -> v=%0b d=%02h l=%0b", v_o[0], d_o[0], l_o[0]);
        check("release_data", 0, d_o[0], 8'd3);
        check("release_last", 0, 8'(l_o[0]), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hs_burst_source.md
Name: hs_burst_source

Overview:
- Upstream producer stage that feeds the ready-beat handshake counter stage.
- Generates fixed-length bursts of incrementing data words on a valid/ready interface.
- Holds each word stable until accepted, and inserts a programmable idle gap between bursts.
- Used as the stimulus/traffic stage in handshake experiments and as a reusable sequence generator.

Parameters:
DATA_W, 8, width of data_out
BURST_LEN, 4, beats per burst (legal 1..255)
GAP_CYC, 2, idle cycles with valid_out=0 between bursts (legal 0..255)
START_VAL, 0, first data value after reset

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enable  input  1  permission to start a new burst
ready_in  input  1  downstream ready
valid_out  output  1  data_out valid
data_out  output  DATA_W  payload word
last_out  output  1  high with the final beat of each burst
burst_cnt  output  8  number of completed bursts, wraps 255->0
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (sys_clk), reset synchronous and active-high (rst).
- Reset values, applied at the first sys_clk edge with rst=1:
  - state=IDLE
  - valid_out=0, last_out=0, busy=0
  - data_out=START_VAL, burst_cnt=0
  - internal beat index=0, gap counter=0
- Handshake (xfer) = valid_out & ready_in sampled at the rising edge. All outputs are registered; there is no combinational path from ready_in to any output.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - valid_out=0.
  - enable=1 at edge -> SEND. valid_out rises one cycle after enable is sampled high.
- SEND:
  - valid_out=1.
  - data_out and last_out must not change while waiting; valid_out must not drop before xfer.
  - last_out=1 exactly when beat index==BURST_LEN-1.
  - On xfer, not last beat: beat index+1, data_out+1.
  - On xfer, last beat:
    - beat index->0, data_out+1, burst_cnt+1.
    - Next state is GAP if GAP_CYC>0.
    - Otherwise SEND if enable=1, else IDLE.
    - With GAP_CYC=0 and enable=1, valid_out stays high back-to-back and the next burst's first word is presented the next cycle.
- GAP:
  - valid_out=0, last_out=0; gap counter counts GAP_CYC cycles.
  - After the GAP_CYC-th cycle: SEND if enable=1, else IDLE.
  - Exactly GAP_CYC cycles of valid_out=0 when enable stays high.
- Enable deassert mid-burst: the burst always completes; enable is sampled only at the burst boundary (end of SEND or end of GAP) and in IDLE.
- Arithmetic:
  - data_out increments modulo 2^DATA_W (0xFF->0x00 for DATA_W=8) and continues across bursts; it is not reset per burst.
  - burst_cnt wraps modulo 256.
- BURST_LEN=1: every beat has last_out=1.
- Reset mid-operation: rst dominates all other inputs. An in-flight word is abandoned and is not counted. Outputs return to reset values at that edge, and the sequence restarts at START_VAL.
- ready_in high while valid_out=0 has no effect.

Test Plan:
1. Reset/idle: rst=1 for 2 cycles, enable=0, ready_in=1 -> valid_out=0, data_out=0, burst_cnt=0, busy=0 for all cycles.
2. Full-rate burst: defaults, enable=1, ready_in=1 constantly ->
   - data 0,1,2,3 on 4 consecutive cycles; last_out only with 3.
   - Then 2 cycles valid_out=0, then 4,5,6,7.
   - burst_cnt=1 after the cycle carrying 3.
3. Backpressure: ready_in pattern 0,1,0,0,1,0,1,... ->
   - data_out and last_out held constant while valid_out=1 and ready_in=0.
   - Exactly one increment per ready_in=1 cycle.
   - No drop of valid_out before acceptance.
4. Enable drop mid-burst: enable=1 then 0 after first beat accepted -> beats 1,2,3 still delivered, then IDLE (busy=0, valid_out=0), burst_cnt=1.
5. Wrap and zero gap: GAP_CYC=0, START_VAL=0xFC, enable=1, ready_in=1 ->
   - Continuous valid_out with sequence FC,FD,FE,FF,00,01...
   - last_out on FF and 03.
6. Reset mid-burst: assert rst for 1 cycle while valid_out=1, data_out=2, ready_in=0 ->
   - Next cycle valid_out=0, data_out=0, burst_cnt=0.
   - With enable=1, a new burst starts from 0.
